// File: rtl/gpio_port.sv
// Bidirectional GPIO bus slave: direction, output data, synchronised input
// sampling, rising/falling edge capture and a maskable level interrupt.
module gpio_port #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             wr_en,
   input  logic [4:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [2:0] A_MODER = 3'd0;
   localparam logic [2:0] A_IDR   = 3'd1;
   localparam logic [2:0] A_ODR   = 3'd2;
   localparam logic [2:0] A_IER   = 3'd3;
   localparam logic [2:0] A_RISE  = 3'd4;
   localparam logic [2:0] A_FALL  = 3'd5;
   localparam logic [2:0] A_ISR   = 3'd6;

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_moder;
   logic [WIDTH-1:0] r_odr;
   logic [WIDTH-1:0] r_ier;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [WIDTH-1:0] r_isr;
   logic             r_irq;

   logic [2:0]       w_sel;
   logic             w_wr;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_rise_ev;
   logic [WIDTH-1:0] w_fall_ev;
   logic [WIDTH-1:0] w_w1c;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_sel    = addr[4:2];
   assign w_wr     = ce & wr_en;
   assign w_wd     = wdata[WIDTH-1:0];
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_unused = ^{wdata, addr[1:0]};

   // Pins are sampled whatever their direction, so outputs read back.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_prev <= '0;
      end else begin
         r_sync[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= w_sync;
      end
   end

   assign w_rise_ev = w_sync & ~r_prev & r_rise;
   assign w_fall_ev = ~w_sync & r_prev & r_fall;
   assign w_w1c     = (w_wr && w_sel == A_ISR) ? w_wd : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_moder <= '0;
         r_odr   <= '0;
         r_ier   <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else if (w_wr) begin
         case (w_sel)
            A_MODER: r_moder <= w_wd;
            A_ODR:   r_odr   <= w_wd;
            A_IER:   r_ier   <= w_wd;
            A_RISE:  r_rise  <= w_wd;
            A_FALL:  r_fall  <= w_wd;
            default: ;
         endcase
      end
   end

   // A new edge on a bit being cleared in the same cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_isr <= '0;
         r_irq <= 1'b0;
      end else begin
         r_isr <= (r_isr & ~w_w1c) | w_rise_ev | w_fall_ev;
         r_irq <= |(r_isr & r_ier);
      end
   end

   always_comb begin
      w_rdata = '0;
      if (ce) begin
         case (w_sel)
            A_MODER: w_rdata = 32'(r_moder);
            A_IDR:   w_rdata = 32'(w_sync);
            A_ODR:   w_rdata = 32'(r_odr);
            A_IER:   w_rdata = 32'(r_ier);
            A_RISE:  w_rdata = 32'(r_rise);
            A_FALL:  w_rdata = 32'(r_fall);
            A_ISR:   w_rdata = 32'(r_isr);
            default: w_rdata = '0;
         endcase
      end
   end

   assign rdata    = w_rdata;
   assign gpio_out = r_odr;
   assign gpio_oe  = r_moder;
   assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port (WIDTH=8, SYNC_STAGES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gpio_port;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        wr_en;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      ce    = 1'b1;
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
      wdata = '0;
   endtask

   task automatic rdchk(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
      ce    = 1'b1;
      wr_en = 1'b0;
      addr  = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   initial begin
      reset   = 1'b1;
      ce      = 1'b0;
      wr_en   = 1'b0;
      addr    = '0;
      wdata   = '0;
      gpio_in = 8'hFF;

      // 1: reset with pins high
      tick();
      tick();
      chk("rst_out", 32'(gpio_out), 32'h0);
      chk("rst_oe", 32'(gpio_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      rdchk("rst_rd_ce0", 5'h00, 32'h0);
      tick();
      rdchk("rst_moder", 5'h00, 32'h0);
      rdchk("rst_odr", 5'h08, 32'h0);
      rdchk("rst_ier", 5'h0C, 32'h0);
      tick();
      rdchk("rst_rise", 5'h10, 32'h0);
      rdchk("rst_fall", 5'h14, 32'h0);
      rdchk("rst_isr", 5'h18, 32'h0);
      rdchk("rst_1c", 5'h1C, 32'h0);
      reset = 1'b0;
      ce    = 1'b0;
      tick();
      tick();
      rdchk("rst_idr", 5'h04, 32'h000000FF);
      tick();
      rdchk("rst_isr_norise", 5'h18, 32'h0);
      chk("rst_irq2", 32'(irq), 32'h0);
      gpio_in = 8'h00;
      tick();
      tick();
      tick();

      // 2: output path
      wr(5'h00, 32'h000000FF);
      wr(5'h08, 32'h000000A5);
      chk("out_oe", 32'(gpio_oe), 32'hFF);
      chk("out_data", 32'(gpio_out), 32'hA5);
      rdchk("out_odr", 5'h08, 32'h000000A5);
      tick();

      // 3: input latency
      gpio_in = 8'h3C;
      tick();
      rdchk("lat_idr_e0", 5'h04, 32'h0);
      tick();
      rdchk("lat_idr_e1", 5'h04, 32'h3C);
      tick();
      rdchk("lat_isr", 5'h18, 32'h0);
      gpio_in = 8'h00;
      tick();
      tick();
      tick();

      // 4: rising edge interrupt and W1C
      wr(5'h10, 32'h01);
      wr(5'h0C, 32'h01);
      gpio_in = 8'h01;
      tick();
      tick();
      rdchk("irq_isr_e1", 5'h18, 32'h0);
      tick();
      rdchk("irq_isr_e2", 5'h18, 32'h01);
      chk("irq_e2", 32'(irq), 32'h0);
      tick();
      chk("irq_e3", 32'(irq), 32'h1);
      wr(5'h18, 32'h01);
      rdchk("w1c_isr", 5'h18, 32'h0);
      tick();
      chk("w1c_irq", 32'(irq), 32'h0);
      gpio_in = 8'h00;
      tick();
      tick();
      tick();
      tick();
      rdchk("nofall_isr", 5'h18, 32'h0);
      tick();

      // 5: set wins over W1C on the same bit
      wr(5'h14, 32'h02);
      gpio_in = 8'h02;
      tick();
      tick();
      tick();
      tick();
      rdchk("sw_pre_isr", 5'h18, 32'h0);
      tick();
      gpio_in = 8'h00;
      tick();
      tick();
      wr(5'h18, 32'h02);
      rdchk("sw_isr", 5'h18, 32'h02);
      chk("sw_irq_masked", 32'(irq), 32'h0);
      tick();

      // 6: masking, reset mid-operation, bounds
      wr(5'h0C, 32'h02);
      tick();
      chk("mask_irq_on", 32'(irq), 32'h1);
      wr(5'h0C, 32'h00);
      tick();
      chk("mask_irq_off", 32'(irq), 32'h0);
      rdchk("mask_isr_kept", 5'h18, 32'h02);
      tick();
      wr(5'h0C, 32'h02);
      tick();
      chk("mid_irq_pre", 32'(irq), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_irq", 32'(irq), 32'h0);
      rdchk("mid_isr", 5'h18, 32'h0);
      rdchk("mid_moder", 5'h00, 32'h0);
      tick();
      wr(5'h00, 32'hFFFFFFFF);
      rdchk("bnd_moder", 5'h00, 32'h000000FF);
      tick();
      wr(5'h1C, 32'hFFFFFFFF);
      rdchk("bnd_1c", 5'h1C, 32'h0);
      tick();
      wr(5'h04, 32'h00000055);
      rdchk("bnd_idr_ro", 5'h04, 32'h0);
      tick();
      ce    = 1'b0;
      wr_en = 1'b1;
      addr  = 5'h08;
      wdata = 32'h33;
      tick();
      wr_en = 1'b0;
      rdchk("bnd_ce0_wr", 5'h08, 32'h0);
      tick();
      ce   = 1'b0;
      addr = 5'h00;
      #1;
      chk("bnd_ce0_rd", rdata, 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
